// File: rtl/serial_complementer_n.sv
// serial_complementer_n
//   Multi-lane bit-serial complementer, LSB first. Every lane receives one
//   WIDTH-bit word per frame, one bit per in_valid cycle, and emits that word
//   as a pass-through copy, its two's complement or its ones' complement.
//   All lanes share the frame counter, the latched mode and in_valid.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   sync_clr   synchronous frame abort; the coincident input bit is dropped
//   in_valid   x carries a valid bit this cycle
//   mode       00 pass, 01 two's complement, 10 ones' complement, 11 pass
//   x          serial input bit per lane, LSB first
//   y          registered serial result bit per lane
//   out_valid  y is valid this cycle
//   out_first  y carries bit 0 of a frame
//   out_last   y carries bit WIDTH-1 of a frame
//   ovf        lane input was the most-negative value (two's mode, with out_last)
//
// Per-lane state (two's mode only)
//   state  | meaning
//   COPY   | no 1 seen yet in this frame; y = x
//   INVERT | a 1 has been seen; y = ~x until the frame wraps or aborts
module serial_complementer_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sync_clr,
  input  logic                in_valid,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] x,
  output logic [CHANNELS-1:0] y,
  output logic                out_valid,
  output logic                out_first,
  output logic                out_last,
  output logic [CHANNELS-1:0] ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } lane_state_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  lane_state_t         st_q [CHANNELS];
  lane_state_t         st_d [CHANNELS];

  logic                first_bit, last_bit;
  logic [1:0]          eff_mode;
  logic                twos, ones;
  logic [CHANNELS-1:0] y_d, ovf_d;
  logic                vld_d, first_d, last_d;

  always_comb begin
    first_bit = (cnt_q == '0);
    last_bit  = (cnt_q == CNT_LAST);
    // Bit 0 of a frame uses the live mode; the rest of the frame uses the
    // copy latched on that same cycle.
    eff_mode  = first_bit ? mode : mode_q;
    twos      = (eff_mode == 2'b01);
    ones      = (eff_mode == 2'b10);

    cnt_d   = cnt_q;
    mode_d  = mode_q;
    y_d     = '0;
    ovf_d   = '0;
    vld_d   = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      st_d[i] = st_q[i];
    end

    if (in_valid) begin
      vld_d   = 1'b1;
      first_d = first_bit;
      last_d  = last_bit;
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
      if (first_bit) begin
        mode_d = mode;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (twos) begin
          y_d[i] = (st_q[i] == INVERT) ? ~x[i] : x[i];
          if (st_q[i] == COPY && x[i]) begin
            st_d[i] = INVERT;
          end
          // Sign bit is the first 1 of the word: the input was 100..0.
          ovf_d[i] = last_bit & x[i] & (st_q[i] == COPY);
        end else begin
          y_d[i] = ones ? ~x[i] : x[i];
        end
        if (last_bit) begin
          st_d[i] = COPY;
        end
      end
    end

    if (sync_clr) begin
      cnt_d   = '0;
      mode_d  = mode_q;
      y_d     = '0;
      ovf_d   = '0;
      vld_d   = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        st_d[i] = COPY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      mode_q    <= 2'b00;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i] <= COPY;
      end
      y         <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i] <= st_d[i];
      end
      y         <= y_d;
      ovf       <= ovf_d;
      out_valid <= vld_d;
      out_first <= first_d;
      out_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_serial_complementer_n.sv
// tb_serial_complementer_n
//   Scoreboard bench for serial_complementer_n (WIDTH=16, CHANNELS=4).
//   The driver pushes the expected output bit for every accepted input bit;
//   a monitor pops and compares whenever out_valid is seen.
module tb_serial_complementer_n;

  localparam int W = 16;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sync_clr = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [C-1:0] x = '0;
  logic [C-1:0] y;
  logic         out_valid, out_first, out_last;
  logic [C-1:0] ovf;

  serial_complementer_n #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .sync_clr(sync_clr), .in_valid(in_valid),
    .mode(mode), .x(x), .y(y), .out_valid(out_valid),
    .out_first(out_first), .out_last(out_last), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [C-1:0] y;
    logic         first;
    logic         last;
    logic [C-1:0] ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every out_valid cycle, idle outputs must be zero.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 16'(out_valid), 16'd0);
        end else begin
          e = q.pop_front();
          chk("y", 16'(y), 16'(e.y));
          chk("first", 16'(out_first), 16'(e.first));
          chk("last", 16'(out_last), 16'(e.last));
          chk("ovf", 16'(ovf), 16'(e.ovf));
        end
      end else begin
        chk("idle_outs", {6'd0, y, out_first, out_last, ovf}, 16'd0);
      end
    end
  end

  // stop_kind: 0 full frame, 1 sync_clr at bit stop_at, 2 reset at bit stop_at
  task automatic send_frame(input logic [C-1:0][15:0] w, input logic [C-1:0][15:0] e,
                            input logic [1:0] m, input logic [C-1:0] ovf_e,
                            input bit stall, input int chg_bit,
                            input int stop_kind, input int stop_at);
    exp_t ent;
    for (int b = 0; b < W; b++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
          x = C'($urandom);
          mode = 2'($urandom);
        end
      end
      @(negedge clk);
      for (int i = 0; i < C; i++) x[i] = w[i][b];
      in_valid = 1'b1;
      mode = (chg_bit >= 0 && b >= chg_bit) ? 2'b10 : m;
      if (stop_kind != 0 && b == stop_at) begin
        if (stop_kind == 1) begin
          sync_clr = 1'b1;
          @(posedge clk);
          #1;
          chk("sclr_drop_valid", 16'(out_valid), 16'd0);
          @(negedge clk);
          sync_clr = 1'b0;
          in_valid = 1'b0;
        end else begin
          @(posedge clk);
          #2;
          reset = 1'b1;
          #1;
          chk("rst_y", 16'(y), 16'd0);
          chk("rst_valid", 16'(out_valid), 16'd0);
          chk("rst_first_last", {out_first, out_last}, 16'd0);
          chk("rst_ovf", 16'(ovf), 16'd0);
          @(negedge clk);
          in_valid = 1'b0;
          reset = 1'b0;
        end
        return;
      end
      for (int i = 0; i < C; i++) ent.y[i] = e[i][b];
      ent.first = (b == 0);
      ent.last  = (b == W - 1);
      ent.ovf   = (b == W - 1) ? ovf_e : '0;
      q.push_back(ent);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [C-1:0][15:0] pw;
    #1 reset = 1'b1;
    #2;
    chk("reset_y", 16'(y), 16'd0);
    chk("reset_valid", 16'(out_valid), 16'd0);
    chk("reset_flags", {out_first, out_last}, 16'd0);
    chk("reset_ovf", 16'(ovf), 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // two's complement, lanes {3,2,1,0}
    send_frame({16'h7FFF, 16'h0000, 16'h0001, 16'h00E0},
               {16'h8001, 16'h0000, 16'hFFFF, 16'hFF20}, 2'b01, 4'b0000, 0, -1, 0, 0);
    // most-negative input on lane 0
    send_frame({16'h0000, 16'h0000, 16'h0000, 16'h8000},
               {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 2'b01, 4'b0001, 0, -1, 0, 0);
    // ones' complement
    send_frame({16'h0000, 16'hFFFF, 16'h1234, 16'h0005},
               {16'hFFFF, 16'h0000, 16'hEDCB, 16'hFFFA}, 2'b10, 4'b0000, 0, -1, 0, 0);
    // pass and reserved: 0x8000 must not flag ovf
    pw = {16'h0F0F, 16'h8000, 16'hA5A5, 16'h1234};
    send_frame(pw, pw, 2'b00, 4'b0000, 0, -1, 0, 0);
    send_frame(pw, pw, 2'b11, 4'b0000, 0, -1, 0, 0);
    // stalls plus a mid-frame mode change to 10 at bit 5
    send_frame({16'hFFFF, 16'h8000, 16'h0001, 16'h00E0},
               {16'h0001, 16'h8000, 16'hFFFF, 16'hFF20}, 2'b01, 4'b0100, 1, 5, 0, 0);
    // abort after bit 7, then a clean frame
    send_frame({16'h0000, 16'h0000, 16'h0000, 16'h00E0},
               {16'h0000, 16'h0000, 16'h0000, 16'hFF20}, 2'b01, 4'b0000, 0, -1, 1, 8);
    send_frame({16'h0000, 16'h0000, 16'h0000, 16'h0028},
               {16'h0000, 16'h0000, 16'h0000, 16'hFFD8}, 2'b01, 4'b0000, 0, -1, 0, 0);
    // async reset mid-frame, then a clean frame
    send_frame({16'h0000, 16'h0000, 16'h0000, 16'h00E0},
               {16'h0000, 16'h0000, 16'h0000, 16'hFF20}, 2'b01, 4'b0000, 0, -1, 2, 5);
    @(negedge clk);
    send_frame({16'h0000, 16'h0000, 16'h0000, 16'h0003},
               {16'h0000, 16'h0000, 16'h0000, 16'hFFFD}, 2'b01, 4'b0000, 0, -1, 0, 0);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    chk("drain_queue", 16'(q.size()), 16'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
